// File: rtl/ascon_req_arbiter.sv
// -----------------------------------------------------------------------------
// ascon_req_arbiter
//   Shares a single ascon AEAD core between N_REQ requesters. A round-robin
//   arbiter picks the next requester, its key/nonce/sizes/delay are latched
//   into registers that drive the core, and a small sequencer walks the core
//   through start handshake, busy wait (with watchdog), tag capture and
//   completion / abort signalling. owner_o steers the external FIFO muxes.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_i               per-requester job request (level)
//   key_i, nonce_i      per-requester 128-bit key / nonce, slice k = [128k+:128]
//   ad_size_i,pt_size_i per-requester AD / PT byte counts (DATA_AW each)
//   delay_i             per-requester inter-round delay (DELAY_WIDTH each)
//   gnt_o               one-cycle pulse: config of requester k latched
//   done_o              one-cycle pulse: job k finished, tag_o valid
//   err_o               one-cycle pulse: job k aborted by watchdog
//   tag_o               last captured tag, held until the next capture
//   owner_o             index of the current / last granted requester
//   busy_o              high from LOAD through DONE/ABORT
//   core_*_o            latched configuration and start request to the core
//   core_ready_i        core idle / ready
//   core_tag_valid_i    core tag valid, core_tag_i carries the tag
//   core_flush_o        one-cycle pulse on abort: flush AD/PT/CT FIFOs
// -----------------------------------------------------------------------------
module ascon_req_arbiter #(
    parameter int N_REQ         = 2,
    parameter int DATA_AW       = 7,
    parameter int DELAY_WIDTH   = 16,
    parameter int TIMEOUT_WIDTH = 12,
    localparam int OW           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_i,
    input  logic [N_REQ*128-1:0]         key_i,
    input  logic [N_REQ*128-1:0]         nonce_i,
    input  logic [N_REQ*DATA_AW-1:0]     ad_size_i,
    input  logic [N_REQ*DATA_AW-1:0]     pt_size_i,
    input  logic [N_REQ*DELAY_WIDTH-1:0] delay_i,
    output logic [N_REQ-1:0]             gnt_o,
    output logic [N_REQ-1:0]             done_o,
    output logic [N_REQ-1:0]             err_o,
    output logic [127:0]                 tag_o,
    output logic [OW-1:0]                owner_o,
    output logic                         busy_o,
    output logic [127:0]                 core_key_o,
    output logic [127:0]                 core_nonce_o,
    output logic [DATA_AW-1:0]           core_ad_size_o,
    output logic [DATA_AW-1:0]           core_pt_size_o,
    output logic [DELAY_WIDTH-1:0]       core_delay_o,
    output logic                         core_start_o,
    input  logic                         core_ready_i,
    input  logic                         core_tag_valid_i,
    input  logic [127:0]                 core_tag_i,
    output logic                         core_flush_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        BUSY  = 3'd3,
        DONE  = 3'd4,
        ABORT = 3'd5
    } state_e;

    localparam logic [OW-1:0]            LAST_RST = OW'(N_REQ - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] WD_ONE   = TIMEOUT_WIDTH'(1);
    localparam logic [TIMEOUT_WIDTH-1:0] WD_MAX   = {TIMEOUT_WIDTH{1'b1}};

    state_e                     state_q;
    logic [OW-1:0]              last_q;
    logic [TIMEOUT_WIDTH-1:0]   wdog_q;

    logic [OW-1:0]              cand_s [N_REQ];
    logic [OW-1:0]              pick_s;
    logic                       any_s;

    // One-hot encode a requester index for the gnt/done/err pulse vectors.
    function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Candidate indices in round-robin order: cand_s[j] is last_grant+1+j wrapped.
    always_comb begin
        for (int j = 0; j < N_REQ; j++) begin
            cand_s[j] = OW'((int'(last_q) + j + 1) % N_REQ);
        end
    end

    // Round-robin pick: scan from the farthest candidate back to the nearest so the
    // nearest requesting candidate overwrites the others.
    always_comb begin
        any_s  = |req_i;
        pick_s = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_i[cand_s[j]]) begin
                pick_s = cand_s[j];
            end else begin
                pick_s = pick_s;
            end
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            last_q         <= LAST_RST;
            wdog_q         <= '0;
            gnt_o          <= '0;
            done_o         <= '0;
            err_o          <= '0;
            tag_o          <= '0;
            owner_o        <= '0;
            busy_o         <= 1'b0;
            core_key_o     <= '0;
            core_nonce_o   <= '0;
            core_ad_size_o <= '0;
            core_pt_size_o <= '0;
            core_delay_o   <= '0;
            core_start_o   <= 1'b0;
            core_flush_o   <= 1'b0;
        end else begin
            // Pulse outputs fall back to zero unless a state below raises them.
            gnt_o        <= '0;
            done_o       <= '0;
            err_o        <= '0;
            core_flush_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_s) begin
                        state_q        <= LOAD;
                        gnt_o          <= onehot(pick_s);
                        owner_o        <= pick_s;
                        last_q         <= pick_s;
                        busy_o         <= 1'b1;
                        core_key_o     <= key_i[int'(pick_s)*128 +: 128];
                        core_nonce_o   <= nonce_i[int'(pick_s)*128 +: 128];
                        core_ad_size_o <= ad_size_i[int'(pick_s)*DATA_AW +: DATA_AW];
                        core_pt_size_o <= pt_size_i[int'(pick_s)*DATA_AW +: DATA_AW];
                        core_delay_o   <= delay_i[int'(pick_s)*DELAY_WIDTH +: DELAY_WIDTH];
                    end else begin
                        state_q <= IDLE;
                    end
                end
                LOAD: begin
                    state_q      <= START;
                    core_start_o <= 1'b1;
                end
                START: begin
                    if (core_ready_i) begin
                        state_q      <= BUSY;
                        core_start_o <= 1'b0;
                        wdog_q       <= '0;
                    end else begin
                        state_q <= START;
                    end
                end
                BUSY: begin
                    // A tag arriving in the saturation cycle still completes the job.
                    if (core_tag_valid_i) begin
                        tag_o   <= core_tag_i;
                        done_o  <= onehot(owner_o);
                        state_q <= DONE;
                    end else if ((wdog_q + WD_ONE) == WD_MAX) begin
                        wdog_q       <= WD_MAX;
                        err_o        <= onehot(owner_o);
                        core_flush_o <= 1'b1;
                        state_q      <= ABORT;
                    end else begin
                        wdog_q <= wdog_q + WD_ONE;
                    end
                end
                DONE: begin
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
                ABORT: begin
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_o       <= 1'b0;
                    core_start_o <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_req_arbiter.sv
module tb_ascon_req_arbiter;

    localparam int N_REQ = 2;
    localparam int DAW   = 7;
    localparam int DW    = 16;
    localparam int TW    = 4;

    logic                 clk;
    logic                 rst;
    logic [N_REQ-1:0]     req_i;
    logic [N_REQ*128-1:0] key_i;
    logic [N_REQ*128-1:0] nonce_i;
    logic [N_REQ*DAW-1:0] ad_size_i;
    logic [N_REQ*DAW-1:0] pt_size_i;
    logic [N_REQ*DW-1:0]  delay_i;
    logic [N_REQ-1:0]     gnt_o, done_o, err_o;
    logic [127:0]         tag_o;
    logic [0:0]           owner_o;
    logic                 busy_o;
    logic [127:0]         core_key_o, core_nonce_o;
    logic [DAW-1:0]       core_ad_size_o, core_pt_size_o;
    logic [DW-1:0]        core_delay_o;
    logic                 core_start_o, core_ready_i, core_tag_valid_i, core_flush_o;
    logic [127:0]         core_tag_i;

    int checks = 0;
    int errors = 0;

    logic [127:0]   keys   [2];
    logic [127:0]   nonces [2];
    logic [DAW-1:0] ads    [2];
    logic [DAW-1:0] pts    [2];
    logic [DW-1:0]  dls    [2];

    ascon_req_arbiter #(
        .N_REQ(N_REQ), .DATA_AW(DAW), .DELAY_WIDTH(DW), .TIMEOUT_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .key_i(key_i), .nonce_i(nonce_i),
        .ad_size_i(ad_size_i), .pt_size_i(pt_size_i), .delay_i(delay_i),
        .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .tag_o(tag_o),
        .owner_o(owner_o), .busy_o(busy_o), .core_key_o(core_key_o),
        .core_nonce_o(core_nonce_o), .core_ad_size_o(core_ad_size_o),
        .core_pt_size_o(core_pt_size_o), .core_delay_o(core_delay_o),
        .core_start_o(core_start_o), .core_ready_i(core_ready_i),
        .core_tag_valid_i(core_tag_valid_i), .core_tag_i(core_tag_i),
        .core_flush_o(core_flush_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_gnt"}, 128'(gnt_o), 128'd0);
        chk({tag, "_done"}, 128'(done_o), 128'd0);
        chk({tag, "_err"}, 128'(err_o), 128'd0);
        chk({tag, "_tag"}, tag_o, 128'd0);
        chk({tag, "_owner"}, 128'(owner_o), 128'd0);
        chk({tag, "_busy"}, 128'(busy_o), 128'd0);
        chk({tag, "_start"}, 128'(core_start_o), 128'd0);
        chk({tag, "_flush"}, 128'(core_flush_o), 128'd0);
        chk({tag, "_key"}, core_key_o, 128'd0);
    endtask

    // Called in the LOAD cycle: checks latched config, then runs START/BUSY/DONE.
    task automatic finish(input int k, input logic [127:0] t);
        chk("load_key", core_key_o, keys[k]);
        chk("load_nonce", core_nonce_o, nonces[k]);
        chk("load_ad", 128'(core_ad_size_o), 128'(ads[k]));
        chk("load_pt", 128'(core_pt_size_o), 128'(pts[k]));
        chk("load_delay", 128'(core_delay_o), 128'(dls[k]));
        chk("load_busy", 128'(busy_o), 128'd1);
        chk("load_start", 128'(core_start_o), 128'd0);
        tick();
        chk("start_on", 128'(core_start_o), 128'd1);
        chk("start_gnt", 128'(gnt_o), 128'd0);
        tick();
        chk("busy_start_off", 128'(core_start_o), 128'd0);
        repeat (3) tick();
        core_tag_valid_i = 1'b1;
        core_tag_i       = t;
        tick();
        core_tag_valid_i = 1'b0;
        chk("done", 128'(done_o), 128'(2'b01 << k));
        chk("done_err", 128'(err_o), 128'd0);
        chk("done_tag", tag_o, t);
        tick();
        chk("idle_busy", 128'(busy_o), 128'd0);
        chk("idle_done", 128'(done_o), 128'd0);
    endtask

    // Called in IDLE with req_i set: expects requester k to be granted next cycle.
    task automatic job(input int k, input logic [127:0] t);
        tick();
        chk("gnt", 128'(gnt_o), 128'(2'b01 << k));
        chk("owner", 128'(owner_o), 128'(k));
        finish(k, t);
    endtask

    initial begin
        keys[0]   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        keys[1]   = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
        nonces[0] = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        nonces[1] = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
        ads[0] = 7'd10; ads[1] = 7'd33;
        pts[0] = 7'd20; pts[1] = 7'd101;
        dls[0] = 16'h0003; dls[1] = 16'h1234;
        key_i     = {keys[1], keys[0]};
        nonce_i   = {nonces[1], nonces[0]};
        ad_size_i = {ads[1], ads[0]};
        pt_size_i = {pts[1], pts[0]};
        delay_i   = {dls[1], dls[0]};
        req_i = 2'b00; core_ready_i = 1'b1; core_tag_valid_i = 1'b0; core_tag_i = 128'd0;
        rst = 1'b1;
        tick(); tick();
        chk_idle_zero("reset");
        rst = 1'b0;
        tick();
        chk("idle_noreq_busy", 128'(busy_o), 128'd0);

        // Test 1: single request from requester 0.
        req_i = 2'b01;
        tick();
        req_i = 2'b00;
        chk("t1_gnt", 128'(gnt_o), 128'd1);
        chk("t1_owner", 128'(owner_o), 128'd0);
        finish(0, {16{8'hA5}});

        // Test 3: core not ready for a while in START (requester 1).
        req_i = 2'b10; core_ready_i = 1'b0;
        tick();
        req_i = 2'b00;
        chk("t3_gnt", 128'(gnt_o), 128'd2);
        chk("t3_owner", 128'(owner_o), 128'd1);
        tick();
        chk("t3_start0", 128'(core_start_o), 128'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_start_hold", 128'(core_start_o), 128'd1);
        end
        core_ready_i = 1'b1;
        tick();
        chk("t3_start_drop", 128'(core_start_o), 128'd0);
        tick();
        chk("t3_start_stay", 128'(core_start_o), 128'd0);
        core_tag_valid_i = 1'b1; core_tag_i = 128'h1;
        tick();
        core_tag_valid_i = 1'b0;
        chk("t3_done", 128'(done_o), 128'd2);
        tick();
        chk("t3_done_once", 128'(done_o), 128'd0);
        chk("t3_idle", 128'(busy_o), 128'd0);

        // Test 4: watchdog abort after 15 BUSY cycles (requester 0).
        req_i = 2'b01;
        tick();
        req_i = 2'b00;
        chk("t4_gnt", 128'(gnt_o), 128'd1);
        tick();
        tick();
        repeat (14) tick();
        chk("t4_err_pre", 128'(err_o), 128'd0);
        chk("t4_busy_pre", 128'(busy_o), 128'd1);
        tick();
        chk("t4_err", 128'(err_o), 128'd1);
        chk("t4_flush", 128'(core_flush_o), 128'd1);
        chk("t4_done", 128'(done_o), 128'd0);
        chk("t4_tag_hold", tag_o, 128'h1);
        tick();
        chk("t4_err_off", 128'(err_o), 128'd0);
        chk("t4_flush_off", 128'(core_flush_o), 128'd0);
        chk("t4_idle", 128'(busy_o), 128'd0);

        // Test 5: tag in the saturation cycle wins (requester 1).
        req_i = 2'b10;
        tick();
        req_i = 2'b00;
        chk("t5_gnt", 128'(gnt_o), 128'd2);
        tick();
        tick();
        repeat (14) tick();
        core_tag_valid_i = 1'b1; core_tag_i = {16{8'h3C}};
        tick();
        core_tag_valid_i = 1'b0;
        chk("t5_done", 128'(done_o), 128'd2);
        chk("t5_err", 128'(err_o), 128'd0);
        chk("t5_flush", 128'(core_flush_o), 128'd0);
        chk("t5_tag", tag_o, {16{8'h3C}});
        tick();

        // Test 6: reset in BUSY, then next request goes to requester 0.
        req_i = 2'b01;
        tick();
        req_i = 2'b00;
        chk("t6_gnt", 128'(gnt_o), 128'd1);
        tick(); tick(); tick(); tick();
        chk("t6_busy", 128'(busy_o), 128'd1);
        rst = 1'b1; req_i = 2'b11;
        tick();
        chk_idle_zero("t6_rst");
        rst = 1'b0;

        // Test 2: both requesters held high -> grant order 0,1,0.
        tick();
        chk("t2_gnt0", 128'(gnt_o), 128'd1);
        chk("t2_owner0", 128'(owner_o), 128'd0);
        finish(0, 128'h11);
        job(1, 128'h22);
        job(0, 128'h33);
        req_i = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
